// File: rtl/jk_register_bank_if.sv
// jk_register_bank_if: control inputs and state outputs of the JK register bank
interface jk_register_bank_if #(parameter int WIDTH = 4);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             wrap;
  modport master (output en, mode, J, K, input Q, Qbar, wrap);
  modport slave  (input en, mode, J, K, output Q, Qbar, wrap);
endinterface

// File: rtl/jk_register_bank.sv
// jk_register_bank: WIDTH JK flops usable as JK bank, up/down counter or shift register
module jk_register_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  jk_register_bank_if.slave bus
);
  logic [WIDTH-1:0] q_q, q_d, jk;
  logic             wrap_q, wrap_d;
  always_comb begin
    jk     = (bus.J & ~q_q) | (~bus.K & q_q);
    q_d    = !bus.en           ? q_q :
             bus.mode == 2'b00 ? jk :
             bus.mode == 2'b01 ? q_q + 1'b1 :
             bus.mode == 2'b10 ? q_q - 1'b1 :
                                 {q_q[WIDTH-2:0], bus.J[0]};
    wrap_d = bus.en && ((bus.mode == 2'b01 && &q_q) || (bus.mode == 2'b10 && ~|q_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.Q    = q_q;
  assign bus.Qbar = ~q_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_jk_register_bank.sv
// tb_jk_register_bank: directed scenarios checked against a behavioural model every cycle
module tb_jk_register_bank;
  localparam logic [3:0] RV = 4'b0011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   mq = 0;
  logic mw = 1'b0;
  logic mvalid = 1'b0;
  jk_register_bank_if #(.WIDTH(4)) bus ();
  jk_register_bank #(.WIDTH(4), .RESET_VAL(RV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int model_q(int q, logic [1:0] m, logic [3:0] j, logic [3:0] k);
    logic [3:0] b;
    b = 4'(q);
    if (m == 2'b00) begin
      for (int i = 0; i < 4; i++)
        case ({j[i], k[i]})
          2'b01:   b[i] = 1'b0;
          2'b10:   b[i] = 1'b1;
          2'b11:   b[i] = ~b[i];
          default: b[i] = b[i];
        endcase
      return int'(b);
    end
    if (m == 2'b01) return (q + 1) % 16;
    if (m == 2'b10) return (q + 15) % 16;
    return (q * 2 + int'(j[0])) % 16;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      mvalid <= 1'b1;
      mq     <= int'(RV);
      mw     <= 1'b0;
    end else if (bus.en) begin
      mq <= model_q(mq, bus.mode, bus.J, bus.K);
      mw <= (bus.mode == 2'b01 && mq == 15) || (bus.mode == 2'b10 && mq == 0);
    end else
      mw <= 1'b0;
  end
  always @(negedge clk) begin
    if (mvalid) begin
      n_vec++;
      if (bus.Q !== 4'(mq)) begin
        n_bad++;
        $display("FAIL model_q t=%0t got %b want %b", $time, bus.Q, 4'(mq));
      end
      n_vec++;
      if (bus.Qbar !== ~4'(mq)) begin
        n_bad++;
        $display("FAIL model_qbar t=%0t got %b want %b", $time, bus.Qbar, ~4'(mq));
      end
      n_vec++;
      if (bus.wrap !== mw) begin
        n_bad++;
        $display("FAIL model_wrap t=%0t got %b want %b", $time, bus.wrap, mw);
      end
    end
  end
  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [3:0] j, input logic [3:0] k);
    @(negedge clk);
    rst      = r;
    bus.en   = e;
    bus.mode = m;
    bus.J    = j;
    bus.K    = k;
    @(posedge clk);
    #1;
  endtask
  task automatic lit(input string name, input logic [3:0] q, input logic w);
    n_vec++;
    if (bus.Q !== q || bus.Qbar !== ~q || bus.wrap !== w) begin
      n_bad++;
      $display("FAIL %s got Q=%b Qbar=%b wrap=%b want Q=%b Qbar=%b wrap=%b",
               name, bus.Q, bus.Qbar, bus.wrap, q, ~q, w);
    end
  endtask
  initial begin
    bus.en = 1'b0; bus.mode = 2'b00; bus.J = '0; bus.K = '0;
    step(1, 1, 2'b01, 4'b1111, 4'b1111);
    step(1, 0, 2'b00, 4'b0000, 4'b0000);
    lit("reset", 4'b0011, 1'b0);
    step(0, 1, 2'b00, 4'b0000, 4'b1111);
    lit("jk_clear", 4'b0000, 1'b0);
    step(0, 1, 2'b00, 4'b1010, 4'b0000);
    lit("jk_set", 4'b1010, 1'b0);
    step(0, 1, 2'b00, 4'b0000, 4'b0010);
    lit("jk_reset_bit", 4'b1000, 1'b0);
    step(0, 1, 2'b00, 4'b1111, 4'b1111);
    lit("jk_toggle", 4'b0111, 1'b0);
    step(0, 1, 2'b00, 4'b0000, 4'b0000);
    lit("jk_hold", 4'b0111, 1'b0);
    step(0, 1, 2'b00, 4'b1110, 4'b0001);
    step(0, 1, 2'b01, 4'b0101, 4'b1010);
    lit("up_1111", 4'b1111, 1'b0);
    step(0, 1, 2'b01, 4'b1111, 4'b1111);
    lit("up_wrap", 4'b0000, 1'b1);
    step(0, 1, 2'b01, 4'b0000, 4'b0000);
    lit("up_0001", 4'b0001, 1'b0);
    step(0, 1, 2'b10, 4'b1111, 4'b0000);
    lit("down_0000", 4'b0000, 1'b0);
    step(0, 1, 2'b10, 4'b0000, 4'b1111);
    lit("down_wrap", 4'b1111, 1'b1);
    step(0, 1, 2'b10, 4'b1010, 4'b0101);
    lit("down_1110", 4'b1110, 1'b0);
    step(0, 1, 2'b00, 4'b0000, 4'b1111);
    step(0, 1, 2'b11, 4'b1111, 4'b0000);
    lit("shift_1", 4'b0001, 1'b0);
    step(0, 1, 2'b11, 4'b0110, 4'b1111);
    lit("shift_2", 4'b0010, 1'b0);
    step(0, 1, 2'b11, 4'b1001, 4'b0101);
    lit("shift_3", 4'b0101, 1'b0);
    step(0, 1, 2'b11, 4'b0101, 4'b1010);
    lit("shift_4", 4'b1011, 1'b0);
    step(0, 1, 2'b00, 4'b0101, 4'b1010);
    step(0, 0, 2'b01, 4'b1111, 4'b1111);
    step(0, 0, 2'b10, 4'b0000, 4'b1111);
    step(0, 0, 2'b11, 4'b1111, 4'b0000);
    lit("hold_en0", 4'b0101, 1'b0);
    step(0, 1, 2'b00, 4'b1111, 4'b0000);
    step(0, 0, 2'b01, 4'b0000, 4'b0000);
    lit("no_wrap_en0", 4'b1111, 1'b0);
    step(0, 1, 2'b11, 4'b0001, 4'b0000);
    step(0, 1, 2'b00, 4'b1000, 4'b0000);
    lit("no_wrap_shift", 4'b1111, 1'b0);
    step(1, 1, 2'b01, 4'b0000, 4'b0000);
    lit("reset_on_wrap", 4'b0011, 1'b0);
    step(0, 1, 2'b01, 4'b0000, 4'b0000);
    lit("up_after_reset", 4'b0100, 1'b0);
    step(0, 1, 2'b10, 4'b0000, 4'b0000);
    lit("down_after_reset", 4'b0011, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/jk_register_bank.md
JK_REGISTER_BANK -- requirements
Module: jk_register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of JK storage bits, legal range 2..32.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, a WIDTH-bit value loaded into Q on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: update enable; low means every bit holds.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 JK, 01 count-up, 10 count-down, 11 shift-left.
REQ-007 The block SHALL have port J, input, WIDTH bits: per-bit J in JK mode; J[0] is the serial-in in shift mode.
REQ-008 The block SHALL have port K, input, WIDTH bits: per-bit K in JK mode; ignored in all other modes.
REQ-009 The block SHALL have port Q, output, WIDTH bits: registered state.
REQ-010 The block SHALL have port Qbar, output, WIDTH bits: bitwise complement of Q.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse flagging a counter wrap.
REQ-012 The block SHALL use one clock, clk, with reset rst synchronous and active-high.

Function
REQ-013 Qbar SHALL equal ~Q combinationally at all times, including during reset.
REQ-014 Q SHALL change only on a rising clk edge when rst=1 or en=1; otherwise Q SHALL hold.
REQ-015 Mode 00 (JK) SHALL update each bit i independently: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
REQ-016 Mode 01 (count-up) SHALL toggle bit i when bits 0..i-1 are all 1 (bit 0 always toggles), giving Q+1 modulo 2^WIDTH.
REQ-017 Mode 10 (count-down) SHALL toggle bit i when bits 0..i-1 are all 0 (bit 0 always toggles), giving Q-1 modulo 2^WIDTH.
REQ-018 Mode 11 (shift) SHALL load {Q[WIDTH-2:0], J[0]}, discarding Q[WIDTH-1].
REQ-019 In modes 01, 10 and 11, J (apart from J[0] in mode 11) and K SHALL have no effect.
REQ-020 wrap SHALL be 1 in the cycle after an enabled update where mode=01 and Q was all-ones, or mode=10 and Q was zero; otherwise wrap SHALL be 0.
REQ-021 wrap SHALL be 0 after any cycle with en=0, rst=1, or mode 00/11, even when the Q value matches a wrap condition.
REQ-022 A mode change SHALL take effect on the same edge it is sampled; Q SHALL carry over unchanged and no extra reset SHALL occur.
REQ-023 Update latency SHALL be exactly one clock from the inputs sampled to the new Q; there SHALL be no pipeline or internal buffering.

Reset
REQ-024 On a rising clk edge with rst=1, Q SHALL become RESET_VAL and wrap SHALL become 0, regardless of en, mode, J and K.
REQ-025 rst SHALL take priority over en and over any operation in progress, including a counter at the wrap point.
REQ-026 After rst is released, the first enabled edge SHALL operate on RESET_VAL.
REQ-027 Before the first reset edge, the state SHALL be undefined; the bench SHALL apply rst for at least 1 cycle before checking outputs.

Verification
REQ-028 Scenario 1, JK truth table (WIDTH=4, reset Q=0000, mode=00, en=1): J=1010,K=0000 gives Q=1010; J=0000,K=0010 gives Q=1000; J=1111,K=1111 gives Q=0111; J=K=0000 gives Q=0111; Qbar=1000 throughout the last step.
REQ-029 Scenario 2, up-count wrap (mode=01, en=1 from Q=1110): Q sequence 1111, 0000, 0001; wrap=1 only in the cycle where Q=0000.
REQ-030 Scenario 3, down-count wrap (mode=10 from Q=0001): Q sequence 0000, 1111, 1110; wrap=1 only in the cycle where Q=1111.
REQ-031 Scenario 4, shift (mode=11, Q=0000, J[0] driven 1,0,1,1): Q sequence 0001, 0010, 0101, 1011; wrap stays 0.
REQ-032 Scenario 5, enable/hold (Q=0101, en=0 for 3 cycles, any mode/J/K): Q stays 0101 and wrap stays 0.
REQ-033 Scenario 6, reset mid-operation (counting up at Q=1111, rst=1 on the wrap edge, RESET_VAL=0011): Q=0011 and wrap=0 on that edge; after release, the next up-count gives Q=0100.
